reg_scoreboard: RTL and testbench

Parametrised register scoreboard tracking in-flight writes per architectural register for the RV32IMF pipeline. It replaces single-bit busy flags with per-register saturating in-flight counters. This lets multiple outstanding writes to the same rd (WAW) retire out of order across several writeback ports. It sits beside decode and answers RAW/WAW queries for NUM_RS source ports, and supports squash (kill) and full flush.

---
 rtl/reg_scoreboard_pkg.sv | 9 +
 rtl/reg_scoreboard_if.sv | 31 +++
 rtl/reg_scoreboard_sb_cnt_cell.sv | 26 ++
 rtl/reg_scoreboard.sv | 67 ++++++
 tb/tb_reg_scoreboard.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/reg_scoreboard_pkg.sv
// rv_sb_pkg: shared widths and types for the register scoreboard
package rv_sb_pkg;
  localparam int SB_NUM_REGS = 32;
  localparam int SB_CNT_W = 2;
  localparam int AW = $clog2(SB_NUM_REGS);
  localparam int MAX_CNT = 2 ** SB_CNT_W - 1;
  typedef logic [SB_CNT_W-1:0] sb_cnt_t;
  typedef logic [AW-1:0] reg_addr_t;
endpackage

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: decode-side allocate/release/query bundle of the register scoreboard
interface reg_scoreboard_if
  import rv_sb_pkg::*;
#(
  parameter int NUM_WB = 2,
  parameter int NUM_RS = 3,
  parameter int ADDR_W = AW
);
  logic alloc_valid;
  logic [ADDR_W-1:0] alloc_rd;
  logic alloc_ready;
  logic [NUM_WB-1:0] wb_valid;
  logic [NUM_WB-1:0][ADDR_W-1:0] wb_rd;
  logic kill_valid;
  logic [ADDR_W-1:0] kill_rd;
  logic flush;
  logic [NUM_RS-1:0][ADDR_W-1:0] rs_addr;
  logic [NUM_RS-1:0] rs_busy;
  logic alloc_waw;
  logic any_busy;
  logic err_underflow;
  logic err_overflow;
  modport master (
    output alloc_valid, alloc_rd, wb_valid, wb_rd, kill_valid, kill_rd, flush, rs_addr,
    input alloc_ready, rs_busy, alloc_waw, any_busy, err_underflow, err_overflow
  );
  modport slave (
    input alloc_valid, alloc_rd, wb_valid, wb_rd, kill_valid, kill_rd, flush, rs_addr,
    output alloc_ready, rs_busy, alloc_waw, any_busy, err_underflow, err_overflow
  );
endinterface

// File: rtl/reg_scoreboard_sb_cnt_cell.sv
// sb_cnt_cell: one saturating in-flight write counter with underflow detection
module sb_cnt_cell
  import rv_sb_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W,
  parameter int DW = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc,
  input  logic [DW-1:0] dec,
  input  logic flush,
  output logic [CNT_W-1:0] cnt,
  output logic nonzero,
  output logic underflow
);
  localparam int W = CNT_W + DW + 1;
  logic [W-1:0] up;
  assign up = W'(cnt) + W'(inc);
  assign underflow = up < W'(dec);
  assign nonzero = |cnt;
  // net count update; a release past zero clamps to zero, flush wins over everything
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= (flush || underflow) ? '0 : CNT_W'(up - W'(dec));
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register in-flight write counters answering RAW/WAW hazard queries
module reg_scoreboard
  import rv_sb_pkg::*;
#(
  parameter int NUM_REGS = SB_NUM_REGS,
  parameter int NUM_WB = 2,
  parameter int NUM_RS = 3,
  parameter int CNT_W = SB_CNT_W,
  parameter int ZERO_HARDWIRED = 1,
  parameter int WB_BYPASS = 1
) (
  input logic clk,
  input logic reset_n,
  reg_scoreboard_if.slave sb
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int DW = $clog2(NUM_WB + 2);
  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [NUM_REGS-1:0] nonzero, fwd_busy, uflow;
  logic rd_zero, alloc_fire;
  assign rd_zero = ZERO_HARDWIRED != 0 && sb.alloc_rd == '0;
  assign sb.alloc_ready = rd_zero || cnt[sb.alloc_rd] != {CNT_W{1'b1}};
  assign alloc_fire = sb.alloc_valid && sb.alloc_ready;
  assign sb.alloc_waw = nonzero[sb.alloc_rd];
  assign sb.any_busy = |nonzero;
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    if (ZERO_HARDWIRED != 0 && r == 0) begin : g_zero
      assign cnt[r] = '0;
      assign nonzero[r] = 1'b0;
      assign fwd_busy[r] = 1'b0;
      assign uflow[r] = 1'b0;
    end else begin : g_cell
      logic [DW-1:0] dec;
      // count every release (writeback ports plus kill) that targets this register
      always_comb begin
        dec = DW'(sb.kill_valid && sb.kill_rd == ADDR_W'(r));
        for (int p = 0; p < NUM_WB; p++) dec = dec + DW'(sb.wb_valid[p] && sb.wb_rd[p] == ADDR_W'(r));
      end
      sb_cnt_cell #(.CNT_W(CNT_W), .DW(DW)) u_cell (
        .clk(clk),
        .reset_n(reset_n),
        .inc(alloc_fire && sb.alloc_rd == ADDR_W'(r)),
        .dec(dec),
        .flush(sb.flush),
        .cnt(cnt[r]),
        .nonzero(nonzero[r]),
        .underflow(uflow[r])
      );
      assign fwd_busy[r] = (CNT_W + DW)'(cnt[r]) > (CNT_W + DW)'(dec);
    end
  end
  // source queries, optionally seeing this cycle's releases as already retired
  always_comb begin
    sb.rs_busy = '0;
    for (int k = 0; k < NUM_RS; k++)
      sb.rs_busy[k] = WB_BYPASS != 0 ? fwd_busy[sb.rs_addr[k]] : nonzero[sb.rs_addr[k]];
  end
  // sticky error flags; a flush cycle discards releases and allocations so raises nothing
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sb.err_underflow <= 1'b0;
      sb.err_overflow <= 1'b0;
    end else begin
      sb.err_underflow <= sb.err_underflow || (|uflow && !sb.flush);
      sb.err_overflow <= sb.err_overflow || (sb.alloc_valid && !sb.alloc_ready && !sb.flush);
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: queue-based scoreboard bench with a counting reference model
module tb_reg_scoreboard;
  import rv_sb_pkg::*;
  typedef struct {
    int id;
    logic [2:0] busy;
    logic rdy, waw, any, eu, eo;
  } exp_t;
  logic clk = 0;
  logic reset_n = 0;
  reg_scoreboard_if #(.NUM_WB(2), .NUM_RS(3), .ADDR_W(AW)) sb ();
  reg_scoreboard dut (.clk(clk), .reset_n(reset_n), .sb(sb));
  always #5 clk = ~clk;
  exp_t q[$];
  int checks = 0, passed = 0, step_id = 0;
  int m_cnt[SB_NUM_REGS];
  bit m_eu, m_eo;
  logic av, kv, fl, rn;
  logic [1:0] wv;
  reg_addr_t ard, wr0, wr1, krd;
  reg_addr_t rs[3];
  task automatic idle();
    av = 0; kv = 0; fl = 0; rn = 1; wv = 0;
    ard = 0; wr0 = 0; wr1 = 0; krd = 0;
  endtask
  task automatic cyc();
    exp_t e;
    int dec[SB_NUM_REGS];
    bit rdy;
    @(posedge clk);
    #1;
    reset_n = rn;
    sb.alloc_valid = av; sb.alloc_rd = ard; sb.wb_valid = wv;
    sb.wb_rd[0] = wr0; sb.wb_rd[1] = wr1; sb.kill_valid = kv; sb.kill_rd = krd; sb.flush = fl;
    for (int k = 0; k < 3; k++) sb.rs_addr[k] = rs[k];
    if (!rn) begin
      foreach (m_cnt[r]) m_cnt[r] = 0;
      m_eu = 0; m_eo = 0;
    end
    foreach (dec[r]) dec[r] = int'(wv[0] && wr0 == r) + int'(wv[1] && wr1 == r) + int'(kv && krd == r);
    rdy = ard == 0 || m_cnt[ard] < MAX_CNT;
    e.id = step_id++;
    e.rdy = rdy;
    e.waw = m_cnt[ard] != 0;
    e.any = 0;
    for (int r = 1; r < SB_NUM_REGS; r++) if (m_cnt[r] != 0) e.any = 1;
    for (int k = 0; k < 3; k++) e.busy[k] = rs[k] != 0 && m_cnt[rs[k]] - dec[rs[k]] > 0;
    e.eu = m_eu;
    e.eo = m_eo;
    q.push_back(e);
    if (rn) begin
      if (av && !rdy && !fl) m_eo = 1;
      for (int r = 1; r < SB_NUM_REGS; r++) begin
        int v;
        v = fl ? 0 : m_cnt[r] + int'(av && rdy && ard == r) - dec[r];
        if (v < 0) begin v = 0; m_eu = 1; end
        m_cnt[r] = v;
      end
    end
  endtask
  task automatic chk(input string nm, input int id, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s step %0d: got %0h expected %0h", nm, id, act, exp);
  endtask
  // monitor: compare the oldest expectation whenever outputs are settled mid-cycle
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("rs_busy", e.id, sb.rs_busy, e.busy);
      chk("alloc_ready", e.id, 3'(sb.alloc_ready), 3'(e.rdy));
      chk("alloc_waw", e.id, 3'(sb.alloc_waw), 3'(e.waw));
      chk("any_busy", e.id, 3'(sb.any_busy), 3'(e.any));
      chk("err_underflow", e.id, 3'(sb.err_underflow), 3'(e.eu));
      if (sb.err_overflow !== e.eo)
        $display("warning: err_overflow step %0d got %0b model %0b", e.id, sb.err_overflow, e.eo);
    end
  end
  initial begin
    idle();
    rs[0] = 1; rs[1] = 2; rs[2] = 3;
    rn = 0;
    cyc(); cyc();
    rn = 1;
    cyc();
    rs[0] = 5;
    av = 1; ard = 5;
    repeat (4) cyc();
    idle(); wv = 2'b01; wr0 = 5;
    cyc();
    idle(); cyc();
    wv = 2'b11; wr0 = 5; wr1 = 5;
    cyc();
    idle(); rs[0] = 7; av = 1; ard = 7;
    cyc(); cyc();
    idle(); wv = 2'b11; wr0 = 7; wr1 = 7;
    cyc();
    idle(); cyc();
    rs[1] = 9; av = 1; ard = 9;
    cyc();
    wv = 2'b01; wr0 = 9;
    cyc();
    idle(); cyc();
    kv = 1; krd = 9;
    cyc();
    idle(); rs[0] = 0; av = 1; ard = 0;
    cyc(); cyc();
    idle(); rs[2] = 4; wv = 2'b01; wr0 = 4;
    cyc();
    idle(); rs[0] = 1; rs[1] = 2; rs[2] = 3;
    for (int i = 1; i <= 3; i++) begin av = 1; ard = reg_addr_t'(i); cyc(); end
    idle(); fl = 1; av = 1; ard = 6;
    cyc();
    idle(); cyc();
    av = 1; ard = 1;
    cyc(); cyc();
    idle(); rn = 0;
    cyc();
    idle(); cyc();
    for (int i = 0; i < 400; i++) begin
      av = $urandom_range(0, 2) != 0;
      ard = reg_addr_t'($urandom_range(0, 7));
      wv = 2'($urandom);
      wr0 = reg_addr_t'($urandom_range(1, 7));
      wr1 = reg_addr_t'($urandom_range(1, 7));
      kv = $urandom_range(0, 3) == 0;
      krd = reg_addr_t'($urandom_range(1, 7));
      fl = $urandom_range(0, 24) == 0;
      rn = $urandom_range(0, 149) != 0;
      for (int k = 0; k < 3; k++) rs[k] = reg_addr_t'($urandom_range(0, 7));
      cyc();
    end
    idle(); cyc();
    repeat (4) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
